osd_dem_uart_rx: RTL
====================

// Module: osd_dem_uart_rx
// PURPOSE
//  Host-to-device receive path of the debug UART: consumes DII event packets addressed
//  to this module and delivers one character per payload flit on in_char/in_valid/in_ready.
//  Sits between the debug ring input (after the stat/ctrl register filter) and the
//  device-side character sink; mirrors the transmit packet format (dest, hdr, char flits).
//  Includes a first-word-fall-through character FIFO to absorb packet bursts.
// PARAMETERS
//  DEPTH     8    FIFO entries; power of 2, >= 2
//  CNT_W     16   width of drop_count (used only with OSD_DEM_UART_RX_DROP_EN)
// PORTS
//  clk             in   1      clock
//  rst             in   1      reset, synchronous, active-high
//  debug_in        in   dii_flit {valid, last, data[15:0]} from ring
//  debug_in_ready  out  1      flit accepted when debug_in.valid & debug_in_ready
//  id              in   10     own module address, static after reset
//  in_char         out  8      FIFO head character; 8'h00 whenever in_valid=0
//  in_valid        out  1      FIFO not empty
//  in_ready        in   1      sink pops head when in_valid & in_ready
//  drop_count      out  CNT_W  saturating count of dropped chars (0 without macro)
// BEHAVIOUR
//  Packet format: flit0 data[9:0]=dest; flit1 {type[15:14], subtype[13:10], src[9:0]};
//  flits 2..n data[7:0]=char, data[15:8] ignored. Accepted: dest==id, type=2'b10, subtype=0.
//  FSM (state reg, reset DEST); advances only on accepted flit (valid & ready):
//   DEST:    dest==id -> HDR, else DISCARD; if last -> DEST (1-flit packet, nothing pushed)
//   HDR:     accepted type/subtype -> PAYLOAD, else DISCARD; if last -> DEST (empty packet)
//   PAYLOAD: push data[7:0]; if last -> DEST
//   DISCARD: consume silently; if last -> DEST
//  debug_in_ready: 1 in DEST/HDR/DISCARD; in PAYLOAD = !full (backpressure mode).
//  FIFO: wr/rd ptrs log2(DEPTH)+1 bits, wrap naturally; full = MSBs differ & LSBs equal.
//   Push and pop in same cycle allowed when not full and not empty; count unchanged.
//   When full, ready is 0 in PAYLOAD even if a pop occurs that cycle (no pass-through).
//   Empty FIFO never bypasses: char accepted in cycle N -> in_valid=1 earliest at N+1.
//  Order preserved across packets; no interleaving (ring delivers packets whole).
//  Reset outputs: in_valid=0, in_char=8'h00, drop_count=0, debug_in_ready=1 (state DEST).
//  Reset mid-packet: FIFO flushed, FSM to DEST; remaining flits of that packet are parsed
//   as a new packet (dest mismatch normally discards them) -- upstream resets together.
//  debug_in.valid=0 with last=1 or junk data: ignored, no state change.
// CONFIGURATION
//  OSD_DEM_UART_RX_DROP_EN defined: debug_in_ready=1 in every state; payload flit while
//   full is consumed, char discarded, drop_count += 1 (saturates at all-ones, no wrap).
//   Push-while-full with same-cycle pop still counts as drop (full evaluated pre-pop).
//  Not defined: backpressure as above; drop_count tied to 0; no counter logic built.
// TESTING
//  1 pkt {id, 16'h8000|src, 16'h0041}, in_ready=1 -> in_char=8'h41 valid 1 cycle, one char.
//  2 pkt dest=id+1 with 3 chars -> all flits accepted (ready=1), in_valid stays 0.
//  3 hdr type=2'b00 (reg pkt) to id -> discarded, no push, FSM back to DEST after last.
//  4 DEPTH=8, in_ready=0, pkt with 10 chars -> 8 stored, ready low on 9th; release
//    in_ready -> 'A'..'J' emerge in order, packet completes. With DROP_EN: ready stays 1,
//    8 chars out, drop_count=2.
//  5 back-to-back 2 pkts (1 char each) + in_ready=1 steady -> 2 chars, no lost/dup flit.
//  6 rst asserted after flit1 of a pkt with FIFO holding 3 chars -> in_valid=0 next cycle,
//    drop_count=0, following pkt to id decoded correctly.

Source files
------------

// File: rtl/osd_dem_uart_rx_if.sv
// Bus bundle for osd_dem_uart_rx: DII flit input from the ring and the character output to the sink.
// The slave modport is the receiver; the master modport is the ring/sink side.
interface osd_dem_uart_rx_if;
    localparam int unsigned FLIT_W = 16;
    localparam int unsigned CHAR_W = 8;

    logic              debug_in_valid;
    logic              debug_in_last;
    logic [FLIT_W-1:0] debug_in_data;
    logic              debug_in_ready;
    logic [CHAR_W-1:0] in_char;
    logic              in_valid;
    logic              in_ready;

    modport master (
        output debug_in_valid, debug_in_last, debug_in_data, in_ready,
        input  debug_in_ready, in_char, in_valid
    );

    modport slave (
        input  debug_in_valid, debug_in_last, debug_in_data, in_ready,
        output debug_in_ready, in_char, in_valid
    );
endinterface

// File: rtl/osd_dem_uart_rx.sv
// Debug UART receive path: parses DII event packets addressed to id and queues one char per payload flit.
// Optional OSD_DEM_UART_RX_DROP_EN: never backpressure, drop chars while full and count them.
module osd_dem_uart_rx #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    osd_dem_uart_rx_if.slave bus,
    input  logic [9:0]       id,
    output logic [CNT_W-1:0] drop_count
);
    localparam int unsigned IDX_W  = $clog2(DEPTH);
    localparam int unsigned PTR_W  = IDX_W + 1;
    localparam int unsigned CHAR_W = 8;

    typedef enum logic [1:0] {
        ST_DEST,
        ST_HDR,
        ST_PAYLOAD,
        ST_DISCARD
    } state_t;

    state_t            state_q;
    state_t            state_d;
    logic [CHAR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q;
    logic [PTR_W-1:0]  rd_ptr_q;
    logic              empty;
    logic              full;
    logic              in_payload;
    logic              flit_acc;
    logic              push;
    logic              pop;
    logic              hdr_ok;

    assign empty      = (wr_ptr_q == rd_ptr_q);
    assign full       = (wr_ptr_q[PTR_W-1] != rd_ptr_q[PTR_W-1]) &&
                        (wr_ptr_q[IDX_W-1:0] == rd_ptr_q[IDX_W-1:0]);
    assign in_payload = (state_q == ST_PAYLOAD);
    assign hdr_ok     = (bus.debug_in_data[15:14] == 2'b10) && (bus.debug_in_data[13:10] == 4'b0000);

`ifdef OSD_DEM_UART_RX_DROP_EN
    assign bus.debug_in_ready = 1'b1;
`else
    // Full is judged before any same-cycle pop, so a full FIFO never passes a char through.
    assign bus.debug_in_ready = !(in_payload && full);
`endif

    assign flit_acc     = bus.debug_in_valid && bus.debug_in_ready;
    assign push         = flit_acc && in_payload && !full;
    assign pop          = !empty && bus.in_ready;
    assign bus.in_valid = !empty;
    assign bus.in_char  = empty ? CHAR_W'(0) : mem[rd_ptr_q[IDX_W-1:0]];

    // Packet parser state register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_DEST;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state: advance only on an accepted flit; last always returns to DEST
    always_comb begin
        state_d = state_q;
        if (flit_acc) begin
            case (state_q)
                ST_DEST: state_d = (bus.debug_in_data[9:0] == id) ? ST_HDR : ST_DISCARD;
                ST_HDR:  state_d = hdr_ok ? ST_PAYLOAD : ST_DISCARD;
                default: state_d = state_q;
            endcase
            if (bus.debug_in_last) begin
                state_d = ST_DEST;
            end
        end
    end

    // FIFO pointers; extra MSB distinguishes full from empty
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_q[IDX_W-1:0]] <= bus.debug_in_data[CHAR_W-1:0];
        end
    end

`ifdef OSD_DEM_UART_RX_DROP_EN
    logic [CNT_W-1:0] drop_q;

    // Saturating count of payload chars that arrived while full
    always_ff @(posedge clk) begin
        if (rst) begin
            drop_q <= '0;
        end else if (flit_acc && in_payload && full && (drop_q != {CNT_W{1'b1}})) begin
            drop_q <= drop_q + CNT_W'(1);
        end
    end

    assign drop_count = drop_q;
`else
    assign drop_count = '0;
`endif
endmodule
